// File: rtl/bsg_seq_checker_pkg.sv
// Shared types for the sequence checker: the checker FSM state encoding.
package bsg_seq_checker_pkg;

   typedef enum logic [1:0] {
      eRUN  = 2'd0,
      eDONE = 2'd1,
      eFAIL = 2'd2
   } state_e;

endpackage

// File: rtl/bsg_seq_checker_expect.sv
// Expected-value generator: starts at init_val_p and advances by stride_p
// on each enabled cycle, wrapping modulo 2^width_p.
module bsg_seq_checker_expect #(
   parameter int width_p    = 16,
   parameter int init_val_p = 1,
   parameter int stride_p   = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   output logic [width_p-1:0] val_o
);

   localparam logic [width_p-1:0] init_lp   = width_p'(init_val_p);
   localparam logic [width_p-1:0] stride_lp = width_p'(stride_p);

   logic [width_p-1:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (en_i) val_d = val_q + stride_lp;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) val_q <= init_lp;
      else         val_q <= val_d;
   end

   assign val_o = val_q;

endmodule

// File: rtl/bsg_seq_checker.sv
// Checks an incoming valid/ready stream against an arithmetic sequence and
// reports pass/fail, error count and details of the first mismatch.
module bsg_seq_checker
   import bsg_seq_checker_pkg::*;
#(
   parameter int width_p        = 16,
   parameter int init_val_p     = 1,
   parameter int stride_p       = 1,
   parameter int count_p        = 100,
   parameter int stall_period_p = 0,
   parameter int halt_on_err_p  = 1,
   localparam int cnt_width_lp  = $clog2(count_p+1)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    v_i,
   input  logic [width_p-1:0]      data_i,
   output logic                    ready_o,
   output logic                    done_o,
   output logic                    pass_o,
   output logic [cnt_width_lp-1:0] err_cnt_o,
   output logic [cnt_width_lp-1:0] sample_cnt_o,
   output logic [cnt_width_lp-1:0] first_err_idx_o,
   output logic [width_p-1:0]      first_err_data_o,
   output logic [width_p-1:0]      first_err_exp_o
);

   localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);
   localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(count_p-1);
   localparam logic [cnt_width_lp-1:0] cnt_max_lp  = '1;

   state_e                  state_q, state_d;
   logic [cnt_width_lp-1:0] sample_cnt_q, sample_cnt_d;
   logic [cnt_width_lp-1:0] err_cnt_q, err_cnt_d;
   logic [cnt_width_lp-1:0] first_err_idx_q, first_err_idx_d;
   logic [width_p-1:0]      first_err_data_q, first_err_data_d;
   logic [width_p-1:0]      first_err_exp_q, first_err_exp_d;
   logic [width_p-1:0]      exp_val;
   logic                    stall;
   logic                    accept;
   logic                    mismatch;

   // Backpressure: one stalled cycle at the end of every stall period.
   generate
      if (stall_period_p == 0) begin : g_no_stall
         assign stall = 1'b0;
      end else begin : g_stall
         localparam int stall_w_lp = (stall_period_p > 1) ? $clog2(stall_period_p) : 1;
         localparam logic [stall_w_lp-1:0] stall_last_lp = stall_w_lp'(stall_period_p-1);

         logic [stall_w_lp-1:0] stall_ctr_q, stall_ctr_d;

         always_comb begin
            stall_ctr_d = stall_ctr_q + stall_w_lp'(1);
            if (stall_ctr_q == stall_last_lp) stall_ctr_d = '0;
         end

         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) stall_ctr_q <= '0;
            else         stall_ctr_q <= stall_ctr_d;
         end

         assign stall = (stall_ctr_q == stall_last_lp);
      end
   endgenerate

   assign ready_o  = (state_q == eRUN) & ~stall;
   assign accept   = v_i & ready_o;
   assign mismatch = (data_i != exp_val);

   bsg_seq_checker_expect #(
      .width_p    (width_p),
      .init_val_p (init_val_p),
      .stride_p   (stride_p)
   ) u_expect (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (accept),
      .val_o   (exp_val)
   );

   always_comb begin
      state_d          = state_q;
      sample_cnt_d     = sample_cnt_q;
      err_cnt_d        = err_cnt_q;
      first_err_idx_d  = first_err_idx_q;
      first_err_data_d = first_err_data_q;
      first_err_exp_d  = first_err_exp_q;
      if (accept) begin
         sample_cnt_d = sample_cnt_q + cnt_one_lp;
         if (mismatch) begin
            if (err_cnt_q != cnt_max_lp) err_cnt_d = err_cnt_q + cnt_one_lp;
            // A zero error count means this is the first mismatch seen.
            if (err_cnt_q == '0) begin
               first_err_idx_d  = sample_cnt_q;
               first_err_data_d = data_i;
               first_err_exp_d  = exp_val;
            end
         end
         if (mismatch && (halt_on_err_p == 1)) state_d = eFAIL;
         else if (sample_cnt_q == cnt_last_lp) state_d = eDONE;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q          <= eRUN;
         sample_cnt_q     <= '0;
         err_cnt_q        <= '0;
         first_err_idx_q  <= '0;
         first_err_data_q <= '0;
         first_err_exp_q  <= '0;
      end else begin
         state_q          <= state_d;
         sample_cnt_q     <= sample_cnt_d;
         err_cnt_q        <= err_cnt_d;
         first_err_idx_q  <= first_err_idx_d;
         first_err_data_q <= first_err_data_d;
         first_err_exp_q  <= first_err_exp_d;
      end
   end

   assign done_o           = (state_q != eRUN);
   assign pass_o           = (state_q == eDONE) & (err_cnt_q == '0);
   assign err_cnt_o        = err_cnt_q;
   assign sample_cnt_o     = sample_cnt_q;
   assign first_err_idx_o  = first_err_idx_q;
   assign first_err_data_o = first_err_data_q;
   assign first_err_exp_o  = first_err_exp_q;

endmodule

// File: doc/bsg_seq_checker.md
BSG_SEQ_CHECKER -- requirements
Module: bsg_seq_checker

Interface
REQ-001 SHALL have parameter width_p, default 16: data width of the checked stream.
REQ-002 SHALL have parameter init_val_p, default 1: first expected value.
REQ-003 SHALL have parameter stride_p, default 1: increment between consecutive expected values.
REQ-004 SHALL have parameter count_p, default 100: number of samples to check; legal range is count_p >= 1.
REQ-005 SHALL have parameter stall_period_p, default 0: backpressure period; 0 means never stall.
REQ-006 SHALL have parameter halt_on_err_p, default 1: when 1, stop at the first mismatch.
REQ-007 SHALL define local cnt_width_lp = $clog2(count_p+1), sizing all counters and indices.
REQ-008 clk_i  in  1  single clock; all state updates on posedge.
REQ-009 reset_i  in  1  asynchronous, active-high reset.
REQ-010 v_i  in  1  input sample valid.
REQ-011 data_i  in  width_p  input sample.
REQ-012 ready_o  out  1  checker can accept a sample this cycle.
REQ-013 done_o  out  1  checking finished, by completion or halt.
REQ-014 pass_o  out  1  all count_p samples matched.
REQ-015 err_cnt_o  out  cnt_width_lp  number of mismatches.
REQ-016 sample_cnt_o  out  cnt_width_lp  number of samples accepted.
REQ-017 first_err_idx_o  out  cnt_width_lp  0-based index of the first mismatching sample.
REQ-018 first_err_data_o  out  width_p  received value of the first mismatch.
REQ-019 first_err_exp_o  out  width_p  expected value of the first mismatch.

Function
REQ-020 SHALL define accept = v_i & ready_o; only accepted samples change state.
REQ-021 SHALL hold expected register exp_r; on accept, exp_r <= exp_r + stride_p, truncated modulo 2^width_p (wraps silently).
REQ-022 On accept SHALL compare data_i against exp_r; a mismatch increments err_cnt_r, saturating at all-ones.
REQ-023 On the first mismatch only SHALL capture sample_cnt_r, data_i and exp_r into the first_err registers; later mismatches leave them unchanged.
REQ-024 On accept SHALL increment sample_cnt_r.
REQ-025 SHALL use FSM states eRUN, eDONE, eFAIL.
REQ-026 eRUN -> eFAIL on accept with mismatch when halt_on_err_p = 1; this takes priority over the eDONE transition.
REQ-027 eRUN -> eDONE on an accept that does not go to eFAIL, when sample_cnt_r == count_p-1.
REQ-028 eDONE and eFAIL SHALL be terminal until reset.
REQ-029 Stall counter stall_ctr_r SHALL count 0..stall_period_p-1 every cycle and wrap; stall_r = (stall_ctr_r == stall_period_p-1); when stall_period_p = 0, stall_r is constant 0.
REQ-030 ready_o = (state == eRUN) & ~stall_r; ready_o SHALL depend only on registered state, never on v_i or data_i.
REQ-031 done_o = (state != eRUN); it asserts the cycle after the terminating accept.
REQ-032 pass_o = (state == eDONE) & (err_cnt_r == 0).
REQ-033 v_i while ready_o = 0 SHALL be ignored, with no state change; data_i is don't-care whenever accept = 0.
REQ-034 Every output SHALL be driven from registers or from the registered-state logic in REQ-030 to REQ-032 (no input-to-output combinational path).

Reset
REQ-035 Asserting reset_i SHALL immediately set: state = eRUN, exp_r = init_val_p, sample_cnt_r = 0, err_cnt_r = 0, all first_err registers = 0, stall_ctr_r = 0.
REQ-036 Output values while in reset SHALL be: ready_o = 1 (or 0 if stall_period_p = 1), done_o = 0, pass_o = 0.
REQ-037 Reset asserted mid-run SHALL abort the run; checking restarts from init_val_p after deassertion.

Structure
REQ-038 Package bsg_seq_checker_pkg SHALL hold the state enum (eRUN, eDONE, eFAIL).
REQ-039 The expected-value generator (register with enable, init_val_p and stride_p) SHALL be the sub-module bsg_seq_checker_expect.

Verification
REQ-040 Defaults, drive 1..100 with v_i held 1 -> 100 accepts, done_o=1 the next cycle, pass_o=1, err_cnt_o=0, sample_cnt_o=100.
REQ-041 Defaults, sample 5 sent as 0x00FF -> eFAIL, done_o=1, pass_o=0, err_cnt_o=1, first_err_idx_o=5, first_err_data_o=0x00FF, first_err_exp_o=6, ready_o=0 afterwards.
REQ-042 halt_on_err_p=0, samples 3 and 7 corrupted -> all 100 accepted, err_cnt_o=2, first_err_idx_o=3, pass_o=0, done_o=1.
REQ-043 stall_period_p=4, v_i held 1 -> ready_o pattern 1,1,1,0 repeating; exp_r advances only on accepts; pass_o=1 after 100 accepts.
REQ-044 width_p=4, init_val_p=14, count_p=4, feed 14,15,0,1 -> pass_o=1 (wrap-around case).
REQ-045 reset_i pulsed after 50 accepts -> outputs return to reset values without waiting for a clock edge; then feed 1..100 -> pass_o=1.
